rf_writeback_queue: RTL and testbench

//  Writer side of the Register_File write port (Reg_Write/Write_Register/Write_Data).

---
 rtl/rf_writeback_queue.sv | 133 +++++++++++++
 tb/tb_rf_writeback_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// Write-back queue feeding the register file write port, with forwarding lookups.
// Optional build macro RF_WB_ZERO_DISCARD_EN drops pushes to register 0 and blocks reg-0 hits.
module rf_writeback_queue #(
  parameter int WIDTH    = 32,
  parameter int SELECTOR = 5,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [SELECTOR-1:0]        wr_reg_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       stall_i,
  output logic                       Reg_Write_o,
  output logic [SELECTOR-1:0]        Write_Register_o,
  output logic [WIDTH-1:0]           Write_Data_o,
  input  logic [SELECTOR-1:0]        lookup_reg_1_i,
  input  logic [SELECTOR-1:0]        lookup_reg_2_i,
  output logic                       fwd_hit_1_o,
  output logic [WIDTH-1:0]           fwd_data_1_o,
  output logic                       fwd_hit_2_o,
  output logic [WIDTH-1:0]           fwd_data_2_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SELECTOR-1:0] ent_reg_r  [DEPTH];
  logic [WIDTH-1:0]    ent_data_r [DEPTH];
  logic [DEPTH-1:0]    ent_valid_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;

  logic push_s;
  logic store_s;
  logic pop_s;
  logic empty_s;
  logic full_s;

  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign full_s     = (count_r == CNT_W'(DEPTH));
  assign wr_ready_o = !full_s;
  assign push_s     = wr_valid_i && !full_s;
  assign pop_s      = !empty_s && !stall_i;

`ifdef RF_WB_ZERO_DISCARD_EN
  assign store_s = push_s && (wr_reg_i != {SELECTOR{1'b0}});
`else
  assign store_s = push_s;
`endif

  assign count_o = count_r;
  assign empty_o = empty_s;
  assign full_o  = full_s;

  // Scan from head (oldest) towards tail so the last match is the youngest.
  function automatic logic [WIDTH:0] fwd_lookup(input logic [SELECTOR-1:0] lk);
    logic [PTR_W-1:0] idx;
    logic [WIDTH:0]   res;
    res = {(WIDTH+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_r + PTR_W'(k);
      if (ent_valid_r[idx] && (ent_reg_r[idx] == lk)) begin
        res = {1'b1, ent_data_r[idx]};
      end
    end
`ifdef RF_WB_ZERO_DISCARD_EN
    if (lk == {SELECTOR{1'b0}}) begin
      res = {(WIDTH+1){1'b0}};
    end
`endif
    return res;
  endfunction

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      ent_valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_r[i]  <= {SELECTOR{1'b0}};
        ent_data_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      // Store and pop never hit the same slot: equal pointers mean empty or full.
      if (store_s) begin
        ent_reg_r[wr_ptr_r]   <= wr_reg_i;
        ent_data_r[wr_ptr_r]  <= wr_data_i;
        ent_valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        ent_valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r              <= rd_ptr_r + PTR_W'(1);
      end
      case ({store_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Register file write port driven from the head entry.
  always_comb begin
    Reg_Write_o      = 1'b0;
    Write_Register_o = {SELECTOR{1'b0}};
    Write_Data_o     = {WIDTH{1'b0}};
    if (!empty_s) begin
      Reg_Write_o      = !stall_i;
      Write_Register_o = ent_reg_r[rd_ptr_r];
      Write_Data_o     = ent_data_r[rd_ptr_r];
    end else begin
      Reg_Write_o      = 1'b0;
      Write_Register_o = {SELECTOR{1'b0}};
      Write_Data_o     = {WIDTH{1'b0}};
    end
  end

  // Forwarding ports for the two read-stage lookups.
  always_comb begin
    {fwd_hit_1_o, fwd_data_1_o} = fwd_lookup(lookup_reg_1_i);
    {fwd_hit_2_o, fwd_data_2_o} = fwd_lookup(lookup_reg_2_i);
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: reset, drain order, full, forwarding, wrap, reset flush, reg 0.
module tb_rf_writeback_queue;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        stall;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [4:0]  lk1;
  logic [4:0]  lk2;
  logic        hit1;
  logic [31:0] fdata1;
  logic        hit2;
  logic [31:0] fdata2;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int compared;
  int mismatched;

  rf_writeback_queue dut (
    .clk              (clk),
    .rst              (rst),
    .wr_valid_i       (wr_valid),
    .wr_ready_o       (wr_ready),
    .wr_reg_i         (wr_reg),
    .wr_data_i        (wr_data),
    .stall_i          (stall),
    .Reg_Write_o      (reg_write),
    .Write_Register_o (write_register),
    .Write_Data_o     (write_data),
    .lookup_reg_1_i   (lk1),
    .lookup_reg_2_i   (lk2),
    .fwd_hit_1_o      (hit1),
    .fwd_data_1_o     (fdata1),
    .fwd_hit_2_o      (hit2),
    .fwd_data_2_o     (fdata2),
    .count_o          (count),
    .empty_o          (empty),
    .full_o           (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b0; wr_valid = 1'b0; wr_reg = 5'd0; wr_data = 32'd0;
    stall = 1'b0; lk1 = 5'd0; lk2 = 5'd0;
    tick();
    tick();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready", 64'(wr_ready), 64'd1);
    chk("rst_regwrite", 64'(reg_write), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wreg", 64'(write_register), 64'd0);
    chk("rst_wdata", 64'(write_data), 64'd0);
    chk("rst_hit1", 64'(hit1), 64'd0);
    chk("rst_hit2", 64'(hit2), 64'd0);
    chk("rst_fdata1", 64'(fdata1), 64'd0);
    rst = 1'b1;

    // Single push drains on the next cycle
    wr_valid = 1'b1; wr_reg = 5'd3; wr_data = 32'hDEADBEEF;
    tick();
    wr_valid = 1'b0;
    #1;
    chk("t1_regwrite", 64'(reg_write), 64'd1);
    chk("t1_wreg", 64'(write_register), 64'd3);
    chk("t1_wdata", 64'(write_data), 64'hDEADBEEF);
    tick();
    tick();
    chk("t1_empty", 64'(empty), 64'd1);

    // Fill while stalled, then drain in order
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_valid = 1'b1; wr_reg = 5'(i); wr_data = 32'(i * 32'h11);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_ready", 64'(wr_ready), 64'd0);
    chk("t2_count4", 64'(count), 64'd4);
    wr_valid = 1'b1; wr_reg = 5'd5; wr_data = 32'h55;
    tick();
    wr_valid = 1'b0;
    #1;
    chk("t2_count_after_refuse", 64'(count), 64'd4);
    chk("t2_stalled_regwrite", 64'(reg_write), 64'd0);
    chk("t2_stalled_head", 64'(write_register), 64'd1);
    stall = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain_we", 64'(reg_write), 64'd1);
      chk("t2_drain_reg", 64'(write_register), 64'(i));
      chk("t2_drain_data", 64'(write_data), 64'(i * 32'h11));
      tick();
    end
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_idle_we", 64'(reg_write), 64'd0);

    // Forwarding picks the youngest match
    stall = 1'b1; lk1 = 5'd7; lk2 = 5'd3;
    wr_valid = 1'b1; wr_reg = 5'd7; wr_data = 32'hA;
    tick();
    chk("t3_fwd_a", 64'(fdata1), 64'hA);
    wr_data = 32'hB;
    tick();
    wr_valid = 1'b0;
    #1;
    chk("t3_hit1", 64'(hit1), 64'd1);
    chk("t3_fwd_b", 64'(fdata1), 64'hB);
    chk("t3_hit2", 64'(hit2), 64'd0);
    chk("t3_fdata2", 64'(fdata2), 64'd0);
    stall = 1'b0;
    tick();
    chk("t3_pop_still_hit", 64'(hit1), 64'd1);
    chk("t3_pop_still_data", 64'(fdata1), 64'hB);
    tick();
    chk("t3_drained_hit", 64'(hit1), 64'd0);
    chk("t3_drained_data", 64'(fdata1), 64'd0);
    wr_valid = 1'b1; wr_reg = 5'd7; wr_data = 32'hC;
    #1;
    chk("t3_no_input_fwd", 64'(hit1), 64'd0);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("t3_empty", 64'(empty), 64'd1);

    // Simultaneous push/pop at count 2 with pointer wrap
    stall = 1'b1;
    wr_valid = 1'b1; wr_reg = 5'd8; wr_data = 32'h100;
    tick();
    wr_reg = 5'd9; wr_data = 32'h101;
    tick();
    stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_reg = 5'(10 + i); wr_data = 32'(32'h102 + i);
      #1;
      chk("t4_count", 64'(count), 64'd2);
      chk("t4_reg", 64'(write_register), 64'(8 + i));
      chk("t4_data", 64'(write_data), 64'(32'h100 + i));
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("t4_tail_reg0", 64'(write_register), 64'd18);
    chk("t4_tail_data0", 64'(write_data), 64'h10A);
    tick();
    chk("t4_tail_reg1", 64'(write_register), 64'd19);
    chk("t4_tail_data1", 64'(write_data), 64'h10B);
    tick();
    chk("t4_empty", 64'(empty), 64'd1);

    // Reset discards queued entries
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_reg = 5'(20 + i); wr_data = 32'(32'h200 + i);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("t5_count3", 64'(count), 64'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1; stall = 1'b0;
    #1;
    chk("t5_count0", 64'(count), 64'd0);
    chk("t5_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_write", 64'(reg_write), 64'd0);
      tick();
    end

    // Register 0 handling
    lk1 = 5'd0;
    wr_valid = 1'b1; wr_reg = 5'd0; wr_data = 32'h55;
    #1;
    chk("t6_ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    #1;
`ifdef RF_WB_ZERO_DISCARD_EN
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_hit", 64'(hit1), 64'd0);
    chk("t6_we", 64'(reg_write), 64'd0);
`else
    chk("t6_count", 64'(count), 64'd1);
    chk("t6_we", 64'(reg_write), 64'd1);
    chk("t6_reg", 64'(write_register), 64'd0);
    chk("t6_data", 64'(write_data), 64'h55);
    chk("t6_hit", 64'(hit1), 64'd1);
    chk("t6_fdata", 64'(fdata1), 64'h55);
    tick();
    chk("t6_empty", 64'(empty), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
